// File: rtl/cam_alloc_if.sv
// Request, free and CAM write-port bundle for cam_alloc.
// master = request/free producer side, slave = allocator side.
interface cam_alloc_if #(
  parameter int CNT_N = 32,
  parameter int KEY_W = 8
);
  localparam int ADDR_W = $clog2(CNT_N);

  logic              req_valid_i;
  logic [KEY_W-1:0]  req_key_i;
  logic              req_ready_o;
  logic              free_i;
  logic [ADDR_W-1:0] free_addr_i;
  logic              alloc_o;
  logic [CNT_N-1:0]  alloc_pos_o;
  logic [KEY_W-1:0]  alloc_key_o;
  logic [ADDR_W-1:0] grant_addr_o;
  logic [ADDR_W:0]   cnt_o;
  logic              full_o;
  logic              empty_o;
  logic              error_o;

  modport master (
    output req_valid_i, req_key_i, free_i, free_addr_i,
    input  req_ready_o, alloc_o, alloc_pos_o, alloc_key_o, grant_addr_o,
           cnt_o, full_o, empty_o, error_o
  );

  modport slave (
    input  req_valid_i, req_key_i, free_i, free_addr_i,
    output req_ready_o, alloc_o, alloc_pos_o, alloc_key_o, grant_addr_o,
           cnt_o, full_o, empty_o, error_o
  );
endinterface

// File: rtl/cam_alloc.sv
// CAM line allocator: occupancy bitmap, free-line pick, registered CAM write strobe.
// Define CAM_ALLOC_ROUND_ROBIN_EN to search from a rotating pointer instead of index 0.
module cam_alloc #(
  parameter int CNT_N = 32,
  parameter int KEY_W = 8
) (
  input  logic      clk,
  input  logic      nreset,
  cam_alloc_if.slave bus
);
  localparam int ADDR_W = $clog2(CNT_N);

  logic [CNT_N-1:0]  used_q, used_d;
  logic [ADDR_W:0]   cnt_q;
  logic              full, hs, free_ok, found;
  logic [ADDR_W-1:0] sel;

  logic              alloc_q, err_q;
  logic [CNT_N-1:0]  pos_q;
  logic [KEY_W-1:0]  key_q;
  logic [ADDR_W-1:0] gaddr_q;

  assign full            = (cnt_q == (ADDR_W+1)'(CNT_N));
  assign bus.req_ready_o = nreset & ~full;
  assign hs              = bus.req_valid_i & bus.req_ready_o;
  // Only lines currently marked used may be freed; anything else is a protocol error.
  assign free_ok = bus.free_i
                 && ({1'b0, bus.free_addr_i} < (ADDR_W+1)'(CNT_N))
                 && used_q[bus.free_addr_i];

`ifdef CAM_ALLOC_ROUND_ROBIN_EN
  logic [ADDR_W-1:0] ptr_q;

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < CNT_N; i++) begin
      int idx;
      idx = int'(ptr_q) + i;
      if (idx >= CNT_N) idx = idx - CNT_N;
      if (!found && !used_q[idx]) begin
        found = 1'b1;
        sel   = ADDR_W'(idx);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset)    ptr_q <= '0;
    else if (hs)    ptr_q <= (sel == ADDR_W'(CNT_N-1)) ? '0 : sel + ADDR_W'(1);
  end
`else
  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int i = 0; i < CNT_N; i++) begin
      if (!found && !used_q[i]) begin
        found = 1'b1;
        sel   = ADDR_W'(i);
      end
    end
  end
`endif

  // Search uses registered used_q, so a line freed this cycle is not eligible yet.
  always_comb begin
    used_d = used_q;
    if (hs)      used_d[sel] = 1'b1;
    if (free_ok) used_d[bus.free_addr_i] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      used_q  <= '0;
      cnt_q   <= '0;
      alloc_q <= 1'b0;
      pos_q   <= '0;
      key_q   <= '0;
      gaddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      used_q <= used_d;
      if (hs && !free_ok)      cnt_q <= cnt_q + (ADDR_W+1)'(1);
      else if (!hs && free_ok) cnt_q <= cnt_q - (ADDR_W+1)'(1);
      alloc_q <= hs;
      pos_q   <= hs ? ({{(CNT_N-1){1'b0}}, 1'b1} << sel) : '0;
      key_q   <= hs ? bus.req_key_i : '0;
      gaddr_q <= hs ? sel : '0;
      err_q   <= bus.free_i & ~free_ok;
    end
  end

  assign bus.alloc_o      = alloc_q;
  assign bus.alloc_pos_o  = pos_q;
  assign bus.alloc_key_o  = key_q;
  assign bus.grant_addr_o = gaddr_q;
  assign bus.cnt_o        = cnt_q;
  assign bus.full_o       = full;
  assign bus.empty_o      = (cnt_q == '0);
  assign bus.error_o      = err_q;
endmodule

// File: tb/tb_cam_alloc.sv
// Self-checking bench for cam_alloc: vector table, directed corner sequences,
// and randomized traffic against an occupancy-array reference model.
module tb_cam_alloc;
  localparam int N = 32;
`ifdef CAM_ALLOC_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  cam_alloc_if #(.CNT_N(N), .KEY_W(8)) bus ();
  cam_alloc #(.CNT_N(N), .KEY_W(8)) dut (.clk(clk), .nreset(nreset), .bus(bus));

  int checks = 0;
  int failures = 0;

  bit mused [N];
  int mcnt, mptr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_clear();
    foreach (mused[i]) mused[i] = 1'b0;
    mcnt = 0;
    mptr = 0;
  endtask

  task automatic rst();
    nreset = 1'b0;
    bus.req_valid_i = 1'b0; bus.req_key_i = '0; bus.free_i = 1'b0; bus.free_addr_i = '0;
    @(posedge clk); @(negedge clk);
    chk("ready_in_reset", 32'(bus.req_ready_o), 0);
    model_clear();
    chk("rst_cnt",   32'(bus.cnt_o), 0);
    chk("rst_empty", 32'(bus.empty_o), 1);
    chk("rst_full",  32'(bus.full_o), 0);
    chk("rst_alloc", 32'(bus.alloc_o), 0);
    chk("rst_pos",   bus.alloc_pos_o, 0);
    chk("rst_key",   32'(bus.alloc_key_o), 0);
    chk("rst_gaddr", 32'(bus.grant_addr_o), 0);
    chk("rst_err",   32'(bus.error_o), 0);
    nreset = 1'b1;
  endtask

  // One clock: drive at negedge, predict from the model, check at next negedge.
  task automatic step(input logic v, input logic [7:0] k, input logic f,
                      input logic [4:0] a, output int g);
    bit ready, hs, fok;
    int sel, start;
    logic [31:0] epos;
    bus.req_valid_i = v; bus.req_key_i = k; bus.free_i = f; bus.free_addr_i = a;
    ready = (mcnt < N);
    #1 chk("ready", 32'(bus.req_ready_o), 32'(ready));
    hs  = v && ready;
    sel = -1;
    start = RR ? mptr : 0;
    for (int i = 0; i < N; i++)
      if (sel < 0 && !mused[(start + i) % N]) sel = (start + i) % N;
    fok = f && (int'(a) < N) && mused[a];
    if (hs) begin
      mused[sel] = 1'b1;
      mptr = (sel + 1) % N;
    end
    if (fok) mused[a] = 1'b0;
    mcnt = mcnt + int'(hs) - int'(fok);
    epos = hs ? (32'd1 << sel) : 32'd0;
    g = hs ? sel : -1;
    @(posedge clk); @(negedge clk);
    chk("alloc", 32'(bus.alloc_o), 32'(hs));
    chk("pos",   bus.alloc_pos_o, epos);
    if (hs) begin
      chk("gaddr", 32'(bus.grant_addr_o), 32'(sel));
      chk("key",   32'(bus.alloc_key_o), 32'(k));
    end
    chk("cnt",   32'(bus.cnt_o), 32'(mcnt));
    chk("full",  32'(bus.full_o), 32'(mcnt == N));
    chk("empty", 32'(bus.empty_o), 32'(mcnt == 0));
    chk("err",   32'(bus.error_o), 32'(f && !fok));
  endtask

  typedef struct {
    logic v; logic [7:0] k; logic f; logic [4:0] a;
    logic e_alloc; int e_g; int e_cnt; logic e_err;
  } vec_t;

  vec_t tbl [10];

  initial begin
    int g;
    bus.req_valid_i = 1'b0; bus.req_key_i = '0; bus.free_i = 1'b0; bus.free_addr_i = '0;

    tbl[0] = '{1'b1, 8'h11, 1'b0, 5'd0, 1'b1, 0, 1, 1'b0};
    tbl[1] = '{1'b1, 8'h22, 1'b0, 5'd0, 1'b1, 1, 2, 1'b0};
    tbl[2] = '{1'b1, 8'h33, 1'b0, 5'd0, 1'b1, 2, 3, 1'b0};
    tbl[3] = '{1'b1, 8'h44, 1'b0, 5'd0, 1'b1, 3, 4, 1'b0};
    tbl[4] = '{1'b1, 8'h55, 1'b1, 5'd2, 1'b1, 4, 4, 1'b0};
    tbl[5] = '{1'b1, 8'h66, 1'b0, 5'd0, 1'b1, RR ? 5 : 2, 5, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b1, 5'd9, 1'b0, -1, 5, 1'b1};
    tbl[7] = '{1'b0, 8'h00, 1'b1, 5'd0, 1'b0, -1, 4, 1'b0};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 5'd0, 1'b0, -1, 4, 1'b0};
    // Free of the line being granted in the same cycle is a double free.
    tbl[9] = '{1'b1, 8'h77, 1'b1, RR ? 5'd6 : 5'd0, 1'b1, RR ? 6 : 0, 5, 1'b1};

    rst();
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].v, tbl[i].k, tbl[i].f, tbl[i].a, g);
      chk($sformatf("tbl%0d_alloc", i), 32'(bus.alloc_o), 32'(tbl[i].e_alloc));
      if (tbl[i].e_alloc) begin
        chk($sformatf("tbl%0d_gaddr", i), 32'(bus.grant_addr_o), 32'(tbl[i].e_g));
        chk($sformatf("tbl%0d_pos", i), bus.alloc_pos_o, 32'd1 << tbl[i].e_g);
      end
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.cnt_o), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_err", i), 32'(bus.error_o), 32'(tbl[i].e_err));
    end

    // Fill to full, free line 7, next grant must land on 7.
    rst();
    for (int i = 0; i < N; i++) step(1'b1, 8'(i), 1'b0, 5'd0, g);
    chk("full_after_fill", 32'(bus.full_o), 1);
    chk("ready_after_fill", 32'(bus.req_ready_o), 0);
    step(1'b1, 8'hAA, 1'b0, 5'd0, g);
    chk("no_grant_when_full", 32'(bus.alloc_o), 0);
    step(1'b0, 8'h00, 1'b1, 5'd7, g);
    chk("ready_after_free", 32'(bus.req_ready_o), 1);
    step(1'b1, 8'hBB, 1'b0, 5'd0, g);
    chk("refill_line7", 32'(bus.grant_addr_o), 7);

    // Reset while a grant is pending with 10 lines used.
    rst();
    for (int i = 0; i < 10; i++) step(1'b1, 8'(i + 1), 1'b0, 5'd0, g);
    chk("pre_reset_cnt", 32'(bus.cnt_o), 10);
    nreset = 1'b0; bus.req_valid_i = 1'b1;
    @(posedge clk); @(negedge clk);
    model_clear();
    chk("midrst_cnt",   32'(bus.cnt_o), 0);
    chk("midrst_empty", 32'(bus.empty_o), 1);
    chk("midrst_alloc", 32'(bus.alloc_o), 0);
    nreset = 1'b1;
    step(1'b1, 8'h5A, 1'b0, 5'd0, g);
    chk("post_reset_line0", 32'(bus.grant_addr_o), 0);

    // Allocate 0-2, free 0, request: round-robin skips past the pointer.
    rst();
    for (int i = 0; i < 3; i++) step(1'b1, 8'(i), 1'b0, 5'd0, g);
    step(1'b0, 8'h00, 1'b1, 5'd0, g);
    step(1'b1, 8'hC3, 1'b0, 5'd0, g);
    chk("rr_vs_fixed_grant", 32'(bus.grant_addr_o), RR ? 3 : 0);

    // Randomized traffic against the model.
    rst();
    for (int i = 0; i < 600; i++) begin
      logic v, f;
      logic [4:0] a;
      v = ($urandom_range(0, 9) < 7);
      f = ($urandom_range(0, 9) < 4);
      a = 5'($urandom_range(0, N - 1));
      step(v, 8'($urandom), f, a, g);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
